// File: rtl/edge_det_pkg.sv
// Package for the multi-channel edge detector.
// Provides the per-channel edge mode type and the counter width helper
// that is shared by the top level and the per-channel logic.
package edge_det_pkg;

  // Per-channel edge selection: bit 0 selects rising edges, bit 1 selects falling edges.
  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // Bits needed for a counter that must hold 0..max_val without wrapping.
  function automatic int cnt_w(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/multi_edge_detector_if.sv
// Interface bundling the per-channel event signals of multi_edge_detector.
//   target  : raw asynchronous inputs            (master -> slave)
//   mode    : 2 bits per channel, ch i at [2i+1:2i] (master -> slave)
//   clr     : per-channel pending clear          (master -> slave)
//   level   : debounced level                    (slave -> master)
//   pulse   : one-cycle accepted-edge pulse      (slave -> master)
//   rpt     : one-cycle auto-repeat pulse        (slave -> master)
//   pending : sticky event flag                  (slave -> master)
interface multi_edge_detector_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0]   target;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0]   clr;
  logic [N_CH-1:0]   level;
  logic [N_CH-1:0]   pulse;
  logic [N_CH-1:0]   rpt;
  logic [N_CH-1:0]   pending;

  modport master (
    output target, mode, clr,
    input  level, pulse, rpt, pending
  );

  modport slave (
    input  target, mode, clr,
    output level, pulse, rpt, pending
  );
endinterface

// File: rtl/edge_det_channel.sv
// One channel of the edge detector: synchroniser, debounce counter,
// edge pulse, hold-to-repeat counter and sticky pending flag.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   target_i    : raw asynchronous input
//   mode_i      : edge selection, sampled on the accepting edge
//   clr_i       : pending clear (set has priority)
//   level_o     : debounced level
//   pulse_o     : one-cycle pulse on accepted edge matching mode
//   rpt_o       : one-cycle auto-repeat pulse
//   pending_o   : sticky flag set by pulse_o or rpt_o
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       target_i,
  input  edge_mode_t mode_i,
  input  logic       clr_i,
  output logic       level_o,
  output logic       pulse_o,
  output logic       rpt_o,
  output logic       pending_o
);

  localparam int DB_W   = cnt_w(DEBOUNCE_CYCLES);
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W   = cnt_w(RC_MAX);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  // Down-counter reload values: the counter reaches zero on the edge the repeat is due.
  localparam logic [RC_W-1:0] RD_LOAD = RC_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RC_W-1:0] RP_LOAD = RC_W'(REPEAT_PERIOD - 1);
  localparam logic            REP_EN  = (REPEAT_DELAY > 0) ? 1'b1 : 1'b0;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic [RC_W-1:0]        rep_cnt_q, rep_cnt_d;
  logic                   rep_act_q, rep_act_d;
  logic                   rpt_q, rpt_d;
  logic                   pending_q, pending_d;

  logic       sync_s;
  logic       differ_s;
  logic       accept_s;
  logic       rise_acc_s;
  logic       fall_acc_s;
  logic [1:0] mode_bits_s;

  assign mode_bits_s = mode_i;
  assign sync_s      = sync_q[SYNC_STAGES-1];
  assign differ_s    = sync_s ^ level_q;
  assign accept_s    = differ_s && (db_cnt_q == DB_LAST);
  assign rise_acc_s  = accept_s & sync_s;
  assign fall_acc_s  = accept_s & ~sync_s;

  // Synchroniser shift chain, oldest sample in the top bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], target_i};
    end
  end

  // Debounce: count consecutive disagreeing samples, accept on the last one.
  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    if (!differ_s) begin
      db_cnt_d = '0;
    end else if (accept_s) begin
      level_d  = sync_s;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  assign pulse_d = (rise_acc_s & mode_bits_s[0]) | (fall_acc_s & mode_bits_s[1]);

  // Repeat scheduler; a fall accepted on a due edge wins and suppresses the repeat.
  always_comb begin
    rep_act_d = rep_act_q;
    rep_cnt_d = rep_cnt_q;
    rpt_d     = 1'b0;
    if (fall_acc_s) begin
      rep_act_d = 1'b0;
      rep_cnt_d = '0;
    end else if (rise_acc_s) begin
      rep_act_d = REP_EN & mode_bits_s[0];
      rep_cnt_d = RD_LOAD;
    end else if (rep_act_q) begin
      if (rep_cnt_q == '0) begin
        rpt_d     = 1'b1;
        rep_cnt_d = RP_LOAD;
      end else begin
        rep_cnt_d = rep_cnt_q - RC_W'(1);
      end
    end else begin
      rep_cnt_d = rep_cnt_q;
    end
  end

  // Pending: a new event on the same edge as clr keeps the flag set.
  always_comb begin
    if (pulse_d | rpt_d) begin
      pending_d = 1'b1;
    end else if (clr_i) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Channel state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      pulse_q   <= 1'b0;
      rep_cnt_q <= '0;
      rep_act_q <= 1'b0;
      rpt_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      rep_cnt_q <= rep_cnt_d;
      rep_act_q <= rep_act_d;
      rpt_q     <= rpt_d;
      pending_q <= pending_d;
    end
  end

  assign level_o   = level_q;
  assign pulse_o   = pulse_q;
  assign rpt_o     = rpt_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/multi_edge_detector.sv
// N-channel debounced edge/event detector feeding the player control FSM.
// Ports:
//   clk    : system clock
//   rst    : asynchronous reset, active-high
//   bus_if : slave side of multi_edge_detector_if (target/mode/clr in,
//            level/pulse/rpt/pending out); every output comes from a flop.
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_edge_detector_if.slave  bus_if
);

  if (N_CH < 1) begin : g_bad_n_ch
    $error("multi_edge_detector: N_CH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("multi_edge_detector: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("multi_edge_detector: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 0) begin : g_bad_rpt_delay
    $error("multi_edge_detector: REPEAT_DELAY must be >= 0");
  end
  if (REPEAT_PERIOD < 1) begin : g_bad_rpt_period
    $error("multi_edge_detector: REPEAT_PERIOD must be >= 1");
  end

  logic [N_CH-1:0] level_s;
  logic [N_CH-1:0] pulse_s;
  logic [N_CH-1:0] rpt_s;
  logic [N_CH-1:0] pending_s;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_det_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .target_i  (bus_if.target[i]),
      .mode_i    (edge_mode_t'(bus_if.mode[2*i +: 2])),
      .clr_i     (bus_if.clr[i]),
      .level_o   (level_s[i]),
      .pulse_o   (pulse_s[i]),
      .rpt_o     (rpt_s[i]),
      .pending_o (pending_s[i])
    );
  end

  assign bus_if.level   = level_s;
  assign bus_if.pulse   = pulse_s;
  assign bus_if.rpt     = rpt_s;
  assign bus_if.pending = pending_s;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed testbench for multi_edge_detector
// (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4, N_CH=4).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_multi_edge_detector;

  localparam int N_CH = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  multi_edge_detector_if #(.N_CH(N_CH)) ev_bus ();

  multi_edge_detector #(
    .N_CH            (N_CH),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (ev_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [15:0] obs;
    rst = 1'b0;
    ev_bus.target = 4'b0000;
    ev_bus.mode   = 8'h00;
    ev_bus.clr    = 4'b0000;
    #1 rst = 1'b1;
    #1;
    obs = {ev_bus.level, ev_bus.pulse, ev_bus.rpt, ev_bus.pending};
    total++;
    if (obs !== 16'h0000) begin
      bad++;
      $display("FAIL reset_async got=%h exp=0000", obs);
    end
    ev_bus.target = 4'b1111;
    repeat (8) @(negedge clk);
    obs = {ev_bus.level, ev_bus.pulse, ev_bus.rpt, ev_bus.pending};
    total++;
    if (obs !== 16'h0000) begin
      bad++;
      $display("FAIL reset_held got=%h exp=0000", obs);
    end
    ev_bus.target = 4'b0000;
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // ch0 rise, mode 01: accepted 5 edges after first sampling edge.
  task automatic test_rise_pulse();
    logic [15:0] obs;
    logic [15:0] exp;
    ev_bus.mode      = 8'b0000_0001;
    ev_bus.target[0] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      obs = {ev_bus.level, ev_bus.pulse, ev_bus.rpt, ev_bus.pending};
      exp = {(k >= 5) ? 4'b0001 : 4'b0000, (k == 5) ? 4'b0001 : 4'b0000,
             4'b0000, (k >= 5) ? 4'b0001 : 4'b0000};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL rise_pulse k=%0d got=%h exp=%h", k, obs, exp);
      end
    end
    // Fall is accepted one edge before the first repeat would be due.
    ev_bus.target[0] = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      obs = {ev_bus.level, ev_bus.pulse, ev_bus.rpt, ev_bus.pending};
      exp = {(k < 5) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000, 4'b0001};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL rise_fall_nopulse k=%0d got=%h exp=%h", k, obs, exp);
      end
    end
    ev_bus.clr[0] = 1'b1;
    @(negedge clk);
    ev_bus.clr[0] = 1'b0;
    total++;
    if (ev_bus.pending !== 4'b0000) begin
      bad++;
      $display("FAIL rise_clr got=%b exp=0000", ev_bus.pending);
    end
  endtask

  // ch1 high for 3 samples only: shorter than the debounce window.
  task automatic test_glitch();
    logic [15:0] obs;
    ev_bus.mode      = 8'b0000_1100;
    ev_bus.target[1] = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      obs = {ev_bus.level, ev_bus.pulse, ev_bus.rpt, ev_bus.pending};
      total++;
      if (obs !== 16'h0000) begin
        bad++;
        $display("FAIL glitch k=%0d got=%h exp=0000", k, obs);
      end
      if (k == 2) ev_bus.target[1] = 1'b0;
    end
  endtask

  // ch2: pass 0 with mode 10 (fall only), pass 1 with mode 00 (level only).
  task automatic test_fall_mode();
    logic [11:0] obs;
    logic [11:0] exp;
    logic [3:0]  fpulse;
    for (int pass = 0; pass < 2; pass++) begin
      ev_bus.mode      = (pass == 0) ? 8'b0010_0000 : 8'b0000_0000;
      fpulse           = (pass == 0) ? 4'b0100 : 4'b0000;
      ev_bus.target[2] = 1'b1;
      for (int k = 0; k <= 19; k++) begin
        @(negedge clk);
        obs = {ev_bus.level, ev_bus.pulse | ev_bus.rpt, ev_bus.pending};
        exp = {(k >= 5) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0000};
        total++;
        if (obs !== exp) begin
          bad++;
          $display("FAIL fall_mode_rise pass=%0d k=%0d got=%h exp=%h", pass, k, obs, exp);
        end
      end
      ev_bus.target[2] = 1'b0;
      for (int k = 0; k <= 7; k++) begin
        @(negedge clk);
        obs = {ev_bus.level, ev_bus.pulse | ev_bus.rpt, ev_bus.pending};
        exp = {(k < 5) ? 4'b0100 : 4'b0000, (k == 5) ? fpulse : 4'b0000,
               (k >= 5) ? fpulse : 4'b0000};
        total++;
        if (obs !== exp) begin
          bad++;
          $display("FAIL fall_mode_fall pass=%0d k=%0d got=%h exp=%h", pass, k, obs, exp);
        end
      end
      ev_bus.clr[2] = 1'b1;
      @(negedge clk);
      ev_bus.clr[2] = 1'b0;
    end
  endtask

  // ch3 held: rpt at R+8, R+12, ... ; the fall lands on a due edge (R+36).
  task automatic test_repeat();
    logic [11:0] obs;
    logic [11:0] exp;
    ev_bus.mode      = 8'b0100_0000;
    ev_bus.target[3] = 1'b1;
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk);
      obs = {ev_bus.level, ev_bus.pulse, ev_bus.rpt};
      exp = {(k >= 5 && k < 41) ? 4'b1000 : 4'b0000,
             (k == 5) ? 4'b1000 : 4'b0000,
             (k >= 13 && k <= 37 && ((k - 13) % 4) == 0) ? 4'b1000 : 4'b0000};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL repeat k=%0d got=%h exp=%h", k, obs, exp);
      end
      if (k == 35) ev_bus.target[3] = 1'b0;
    end
    total++;
    if (ev_bus.pending !== 4'b1000) begin
      bad++;
      $display("FAIL repeat_pending got=%b exp=1000", ev_bus.pending);
    end
    ev_bus.clr[3] = 1'b1;
    @(negedge clk);
    ev_bus.clr[3] = 1'b0;
  endtask

  // ch0 mode 11: clr coincides with the fall pulse, then clr alone.
  task automatic test_pending_clr();
    logic [11:0] obs;
    logic [11:0] exp;
    ev_bus.mode      = 8'b0000_0011;
    ev_bus.target[0] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
    end
    total++;
    if (ev_bus.pending !== 4'b0001) begin
      bad++;
      $display("FAIL pend_set got=%b exp=0001", ev_bus.pending);
    end
    ev_bus.target[0] = 1'b0;
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk);
      obs = {ev_bus.pulse, ev_bus.rpt, ev_bus.pending};
      exp = {(j == 5) ? 4'b0001 : 4'b0000, 4'b0000, (j < 6) ? 4'b0001 : 4'b0000};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL pend_clr j=%0d got=%h exp=%h", j, obs, exp);
      end
      if (j == 4) ev_bus.clr[0] = 1'b1;
      if (j == 6) ev_bus.clr[0] = 1'b0;
    end
    ev_bus.mode = 8'h00;
  endtask

  // Reset between edges while ch1 is mid-debounce, then re-acceptance.
  task automatic test_async_reset();
    logic [15:0] obs;
    logic [7:0]  exp;
    ev_bus.mode   = 8'b0100_0100;
    ev_bus.target = 4'b1000;
    repeat (8) @(negedge clk);
    total++;
    if (ev_bus.level !== 4'b1000) begin
      bad++;
      $display("FAIL arst_pre_level got=%b exp=1000", ev_bus.level);
    end
    ev_bus.target = 4'b1010;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    obs = {ev_bus.level, ev_bus.pulse, ev_bus.rpt, ev_bus.pending};
    total++;
    if (obs !== 16'h0000) begin
      bad++;
      $display("FAIL arst_immediate got=%h exp=0000", obs);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      obs = {8'h00, ev_bus.level, ev_bus.pulse};
      exp = {(k >= 5) ? 4'b1010 : 4'b0000, (k == 5) ? 4'b1010 : 4'b0000};
      total++;
      if (obs[7:0] !== exp) begin
        bad++;
        $display("FAIL arst_release k=%0d got=%h exp=%h", k, obs[7:0], exp);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_rise_pulse();
    test_glitch();
    test_fall_mode();
    test_repeat();
    test_pending_clr();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
